// File: rtl/rcv_uart_rx_pkg.sv
// rtl/rcv_uart_rx_pkg.sv - shared parity modes, FSM states and parity helper for the UART receiver
package rcv_uart_rx_pkg;

    localparam int PAR_NONE = 0;
    localparam int PAR_ODD  = 1;
    localparam int PAR_EVEN = 2;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_START   = 3'd1,
        ST_DATA    = 3'd2,
        ST_PAR     = 3'd3,
        ST_STOP    = 3'd4,
        ST_WAIT_HI = 3'd5
    } rx_state_t;

    // Parity bit the transmitter should have sent, given the XOR of the data bits.
    function automatic logic parity_expect(input logic data_xor, input int mode);
        return (mode == PAR_ODD) ? ~data_xor : data_xor;
    endfunction

endpackage

// File: rtl/rcv_fifo.sv
// rtl/rcv_fifo.sv - first-word fall-through FIFO holding received {ferr, perr, data} entries
module rcv_fifo #(
    parameter int WIDTH = 10,
    parameter int DEPTH = 4
) (
    input  logic             clk_i,
    input  logic             reset_i,
    input  logic             push_i,
    input  logic [WIDTH-1:0] push_data_i,
    input  logic             pop_i,
    output logic [WIDTH-1:0] head_o,
    output logic             valid_o,
    output logic             full_o
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = $clog2(DEPTH + 1);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [PTR_W-1:0] wr_ptr_q, rd_ptr_q;
    logic [CNT_W-1:0] count_q;
    logic             do_push, do_pop;

    assign valid_o = (count_q != '0);
    assign full_o  = (count_q == CNT_W'(DEPTH));
    assign head_o  = mem_q[rd_ptr_q];
    // A pop in the same cycle frees the slot, so a push into a full FIFO is still accepted then.
    assign do_pop  = pop_i && valid_o;
    assign do_push = push_i && (!full_o || do_pop);

    // Pointers and occupancy; pointers wrap naturally because DEPTH is a power of two.
    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (do_push) wr_ptr_q <= wr_ptr_q + PTR_W'(1);
            if (do_pop)  rd_ptr_q <= rd_ptr_q + PTR_W'(1);
            case ({do_push, do_pop})
                2'b10:   count_q <= count_q + CNT_W'(1);
                2'b01:   count_q <= count_q - CNT_W'(1);
                default: count_q <= count_q;
            endcase
        end
    end

    // Entry storage; contents are only meaningful while counted as occupied.
    always_ff @(posedge clk_i) begin
        if (do_push) mem_q[wr_ptr_q] <= push_data_i;
    end

endmodule

// File: rtl/rcv_uart_rx.sv
// rtl/rcv_uart_rx.sv - UART receiver with false-start rejection, parity/framing flags and output FIFO
module rcv_uart_rx
    import rcv_uart_rx_pkg::*;
#(
    parameter int CLKS_PER_BIT = 50000,
    parameter int DATA_BITS    = 8,
    parameter int PARITY       = PAR_NONE,
    parameter int FIFO_DEPTH   = 4
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 serial_in,
    output logic [DATA_BITS-1:0] data_out,
    output logic                 parity_err,
    output logic                 frame_err,
    output logic                 valid,
    input  logic                 ready,
    output logic                 overrun,
    input  logic                 overrun_clr
);

    localparam int CNT_W = $clog2(CLKS_PER_BIT);
    localparam int IDX_W = $clog2(DATA_BITS);
    localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(CLKS_PER_BIT - 1);
    localparam logic [CNT_W-1:0] CNT_HALF = CNT_W'(CLKS_PER_BIT / 2 - 1);
    localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(DATA_BITS - 1);

    logic                 rx_meta_q, rx_s_q;
    rx_state_t            state_q, state_d;
    logic [CNT_W-1:0]     cnt_q, cnt_d;
    logic [IDX_W-1:0]     idx_q, idx_d;
    logic [DATA_BITS-1:0] shreg_q, shreg_d;
    logic                 perr_q, perr_d;
    logic                 push;
    logic                 fifo_full, fifo_valid, pop, drop;
    logic [DATA_BITS+1:0] fifo_head;
    logic                 overrun_q;

    // Two-flop synchroniser; resets to the idle-high line level so reset never looks like a start bit.
    always_ff @(posedge clk) begin
        if (reset) begin
            rx_meta_q <= 1'b1;
            rx_s_q    <= 1'b1;
        end else begin
            rx_meta_q <= serial_in;
            rx_s_q    <= rx_meta_q;
        end
    end

    // Frame FSM state and datapath registers; reset discards any partial frame.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
            idx_q   <= '0;
            shreg_q <= '0;
            perr_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            idx_q   <= idx_d;
            shreg_q <= shreg_d;
            perr_q  <= perr_d;
        end
    end

    // Next-state logic: samples are taken when the bit counter reaches zero (mid-bit).
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        idx_d   = idx_q;
        shreg_d = shreg_q;
        perr_d  = perr_q;
        push    = 1'b0;
        if (state_q == ST_IDLE) begin
            if (!rx_s_q) begin
                state_d = ST_START;
                cnt_d   = CNT_HALF;
            end
        end else if (state_q == ST_WAIT_HI) begin
            if (rx_s_q) state_d = ST_IDLE;
        end else if (cnt_q != '0) begin
            cnt_d = cnt_q - CNT_W'(1);
        end else begin
            cnt_d = CNT_FULL;
            case (state_q)
                ST_START: begin
                    if (rx_s_q) begin
                        state_d = ST_IDLE;
                    end else begin
                        state_d = ST_DATA;
                        idx_d   = '0;
                        perr_d  = 1'b0;
                    end
                end
                ST_DATA: begin
                    shreg_d = {rx_s_q, shreg_q[DATA_BITS-1:1]};
                    idx_d   = idx_q + IDX_W'(1);
                    if (idx_q == IDX_LAST) begin
                        state_d = (PARITY != PAR_NONE) ? ST_PAR : ST_STOP;
                    end
                end
                ST_PAR: begin
                    perr_d  = (rx_s_q != parity_expect(^shreg_q, PARITY));
                    state_d = ST_STOP;
                end
                ST_STOP: begin
                    push    = 1'b1;
                    state_d = rx_s_q ? ST_IDLE : ST_WAIT_HI;
                end
                default: state_d = ST_IDLE;
            endcase
        end
    end

    rcv_fifo #(
        .WIDTH(DATA_BITS + 2),
        .DEPTH(FIFO_DEPTH)
    ) u_fifo (
        .clk_i      (clk),
        .reset_i    (reset),
        .push_i     (push),
        .push_data_i({~rx_s_q, perr_q, shreg_q}),
        .pop_i      (pop),
        .head_o     (fifo_head),
        .valid_o    (fifo_valid),
        .full_o     (fifo_full)
    );

    assign pop  = fifo_valid && ready;
    assign drop = push && fifo_full && !pop;

    // Sticky overrun; a new drop wins over a simultaneous clear.
    always_ff @(posedge clk) begin
        if (reset)            overrun_q <= 1'b0;
        else if (drop)        overrun_q <= 1'b1;
        else if (overrun_clr) overrun_q <= 1'b0;
    end

    assign valid      = fifo_valid;
    assign overrun    = overrun_q;
    assign data_out   = fifo_valid ? fifo_head[DATA_BITS-1:0] : '0;
    assign parity_err = fifo_valid ? fifo_head[DATA_BITS]     : 1'b0;
    assign frame_err  = fifo_valid ? fifo_head[DATA_BITS+1]   : 1'b0;

endmodule

// File: tb/tb_rcv_uart_rx.sv
// tb/tb_rcv_uart_rx.sv - self-checking bench for rcv_uart_rx with a frame-level reference model
module tb_rcv_uart_rx;
    import rcv_uart_rx_pkg::*;

    localparam int CPB = 16;
    localparam int DB  = 8;

    logic          clk = 1'b0;
    logic          reset = 1'b1;
    logic          serial_in = 1'b1;
    logic [DB-1:0] data_out;
    logic          parity_err, frame_err, valid;
    logic          ready = 1'b1;
    logic          overrun;
    logic          overrun_clr = 1'b0;

    int   errors = 0;
    int   checks = 0;
    bit   rand_ready = 1'b0;
    int   valid_cycles = 0;
    logic [DB+1:0] got_q[$];
    logic [DB+1:0] exp_q[$];

    rcv_uart_rx #(
        .CLKS_PER_BIT(CPB),
        .DATA_BITS   (DB),
        .PARITY      (PAR_EVEN),
        .FIFO_DEPTH  (4)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .serial_in  (serial_in),
        .data_out   (data_out),
        .parity_err (parity_err),
        .frame_err  (frame_err),
        .valid      (valid),
        .ready      (ready),
        .overrun    (overrun),
        .overrun_clr(overrun_clr)
    );

    always #5 clk = ~clk;

    // Records every entry handed to the consumer, sampled away from the active edge.
    always @(negedge clk) begin
        if (!reset) begin
            if (valid) valid_cycles++;
            if (valid && ready) got_q.push_back({frame_err, parity_err, data_out});
        end
    end

    // Even parity: the parity bit makes the total count of ones even.
    function automatic logic even_pbit(input logic [DB-1:0] d);
        return ($countones(d) % 2) == 1;
    endfunction

    // What the receiver should report for a frame as it appeared on the line.
    function automatic logic [DB+1:0] model_entry(input logic [DB-1:0] d, input logic pbit,
                                                  input logic stop_bit);
        logic perr;
        perr = ($countones({pbit, d}) % 2) != 0;
        return {~stop_bit, perr, d};
    endfunction

    task automatic hold(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
            if (rand_ready) ready = 1'($urandom_range(0, 1));
        end
    endtask

    task automatic send_frame(input logic [DB-1:0] d, input logic pbit, input logic stop_bit,
                              input int stop_len);
        serial_in = 1'b0;
        hold(CPB);
        for (int i = 0; i < DB; i++) begin
            serial_in = d[i];
            hold(CPB);
        end
        serial_in = pbit;
        hold(CPB);
        serial_in = stop_bit;
        hold(stop_len);
        serial_in = 1'b1;
    endtask

    task automatic apply_reset();
        @(posedge clk);
        #1;
        reset = 1'b1;
        hold(3);
        reset = 1'b0;
        got_q.delete();
        exp_q.delete();
        valid_cycles = 0;
    endtask

    task automatic compare_queues(input string name);
        checks++;
        if (got_q.size() !== exp_q.size()) begin
            errors++;
            $display("FAIL %s count: got %0d entries, want %0d", name, got_q.size(), exp_q.size());
        end
        for (int i = 0; i < exp_q.size() && i < got_q.size(); i++) begin
            checks++;
            if (got_q[i] !== exp_q[i]) begin
                errors++;
                $display("FAIL %s entry %0d: got {ferr,perr,data}=%h want %h", name, i, got_q[i], exp_q[i]);
            end
        end
        got_q.delete();
        exp_q.delete();
    endtask

    task automatic test_reset();
        serial_in = 1'b1;
        ready = 1'b1;
        hold(4);
        reset = 1'b0;
        hold(2);
        checks++;
        if ({valid, overrun, data_out, parity_err, frame_err} !== '0) begin
            errors++;
            $display("FAIL reset_outputs: got valid=%b overrun=%b data=%h perr=%b ferr=%b, want all 0",
                     valid, overrun, data_out, parity_err, frame_err);
        end
    endtask

    task automatic test_basic();
        valid_cycles = 0;
        send_frame(8'hA5, even_pbit(8'hA5), 1'b1, CPB);
        exp_q.push_back({2'b00, 8'hA5});
        hold(20);
        checks++;
        if (valid_cycles !== 1) begin
            errors++;
            $display("FAIL basic_valid_pulse: got %0d valid cycles, want 1", valid_cycles);
        end
        compare_queues("basic");
    endtask

    task automatic test_glitch();
        valid_cycles = 0;
        serial_in = 1'b0;
        hold(4);
        serial_in = 1'b1;
        hold(30);
        checks++;
        if (dut.state_q !== ST_IDLE) begin
            errors++;
            $display("FAIL glitch_state: got %0d, want IDLE", dut.state_q);
        end
        checks++;
        if (valid_cycles !== 0 || got_q.size() !== 0) begin
            errors++;
            $display("FAIL glitch_no_push: got %0d valid cycles, want 0", valid_cycles);
        end
    endtask

    task automatic test_parity();
        send_frame(8'h3C, 1'b1, 1'b1, CPB);
        exp_q.push_back(model_entry(8'h3C, 1'b1, 1'b1));
        hold(20);
        compare_queues("parity_err");
    endtask

    task automatic test_frame_err();
        send_frame(8'h55, even_pbit(8'h55), 1'b0, 40);
        exp_q.push_back(model_entry(8'h55, even_pbit(8'h55), 1'b0));
        hold(20);
        compare_queues("frame_err");
        send_frame(8'h12, even_pbit(8'h12), 1'b1, CPB);
        exp_q.push_back({2'b00, 8'h12});
        hold(20);
        compare_queues("after_break");
    endtask

    task automatic fill_without_reading();
        ready = 1'b0;
        for (int b = 1; b <= 5; b++) begin
            send_frame(8'(b), even_pbit(8'(b)), 1'b1, CPB);
            hold(3);
        end
        hold(10);
    endtask

    task automatic test_overrun();
        fill_without_reading();
        checks++;
        if (overrun !== 1'b1) begin
            errors++;
            $display("FAIL overrun_set: got %b, want 1", overrun);
        end
        checks++;
        if (valid !== 1'b1 || data_out !== 8'h01) begin
            errors++;
            $display("FAIL overrun_head: got valid=%b data=%h, want valid=1 data=01", valid, data_out);
        end
        ready = 1'b1;
        hold(10);
        for (int b = 1; b <= 4; b++) exp_q.push_back({2'b00, 8'(b)});
        compare_queues("overrun_order");
        checks++;
        if (overrun !== 1'b1) begin
            errors++;
            $display("FAIL overrun_sticky: got %b, want 1", overrun);
        end
        overrun_clr = 1'b1;
        hold(1);
        overrun_clr = 1'b0;
        hold(1);
        checks++;
        if (overrun !== 1'b0) begin
            errors++;
            $display("FAIL overrun_clear: got %b, want 0", overrun);
        end
    endtask

    task automatic test_reset_mid_frame();
        fill_without_reading();
        serial_in = 1'b0;
        hold(CPB);
        serial_in = 1'b1;
        hold(3 * CPB);
        apply_reset();
        ready = 1'b1;
        hold(20);
        checks++;
        if (valid !== 1'b0 || overrun !== 1'b0) begin
            errors++;
            $display("FAIL reset_mid_frame: got valid=%b overrun=%b, want 0 0", valid, overrun);
        end
        checks++;
        if (got_q.size() !== 0) begin
            errors++;
            $display("FAIL reset_partial_pushed: got %0d entries, want 0", got_q.size());
        end
        send_frame(8'h81, even_pbit(8'h81), 1'b1, CPB);
        exp_q.push_back({2'b00, 8'h81});
        hold(20);
        compare_queues("after_reset");
    endtask

    task automatic test_back_to_back_random();
        logic [DB-1:0] d;
        logic          pbit, stop_bit;
        int            gap;
        rand_ready = 1'b1;
        for (int n = 0; n < 16; n++) begin
            d        = 8'($urandom);
            pbit     = even_pbit(d) ^ ($urandom_range(0, 3) == 0);
            stop_bit = ($urandom_range(0, 4) != 0);
            gap      = stop_bit ? $urandom_range(0, 3) : $urandom_range(4, 8);
            send_frame(d, pbit, stop_bit, CPB);
            exp_q.push_back(model_entry(d, pbit, stop_bit));
            hold(gap);
        end
        rand_ready = 1'b0;
        ready = 1'b1;
        hold(30);
        compare_queues("random");
        checks++;
        if (overrun !== 1'b0) begin
            errors++;
            $display("FAIL random_overrun: got %b, want 0", overrun);
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_glitch();
        test_parity();
        test_frame_err();
        test_overrun();
        test_reset_mid_frame();
        test_back_to_back_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
